// File: rtl/add_seq_pkg.sv
// add_seq_pkg
//   Shared definitions for the multi-precision add sequencer: the adder slice
//   width, the FSM state encoding and a helper that derives the slice count
//   from the operand width.
package add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int sliceCount(int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/add_16_bit.sv
// add_16_bit
//   Shared 16-bit adder datapath with carry in/out.
// Ports
//   a, b      : 16-bit addends
//   carryIn   : carry into bit 0
//   sum       : 16-bit sum
//   carryOut  : carry out of bit 15
module add_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carryIn,
  output logic [15:0] sum,
  output logic        carryOut
);

  assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {16'b0, carryIn};

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
//   Multi-precision add sequencer. Accepts WIDTH-bit operands over a
//   valid/ready handshake and feeds the single add_16_bit instance one
//   16-bit slice per cycle, LSB first, chaining the carry through a register.
//   The result and final carry are held until the consumer takes them.
// Optional feature
//   ADD_SEQ_SUB_EN : adds the in_sub port; when set at accept, b is inverted
//                    slice by slice and the initial carry is forced to 1
//                    (out_cout = 1 then means no borrow).
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   in_a, in_b, in_cin   : operands and carry-in
//   in_sub               : subtract select (ADD_SEQ_SUB_EN only)
//   out_valid / out_ready: result handshake
//   out_sum, out_cout    : registered result and carry-out
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one 16-bit slice added per cycle
// DONE  | result presented, waiting for out_ready
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NSLICE = sliceCount(WIDTH);
  localparam int SCW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [SCW-1:0] LAST_SLICE = SCW'(NSLICE - 1);

  state_t           state, stateNext;
  logic [SCW-1:0]   slice;
  logic             carry;
  logic [WIDTH-1:0] aReg, bReg;
  logic             accept, lastSlice;
  logic [15:0]      aSlice, bSlice, sliceSum;
  logic             sliceCout;
`ifdef ADD_SEQ_SUB_EN
  logic             subReg;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign lastSlice = (slice == LAST_SLICE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = RUN;
      end
      RUN: begin
        if (lastSlice) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Slice mux into the shared adder. The carry register is loaded with the
  // slice-0 carry at accept, so every RUN cycle just uses the register.
  assign aSlice = aReg[SLICE_W*slice +: SLICE_W];
`ifdef ADD_SEQ_SUB_EN
  assign bSlice = subReg ? ~bReg[SLICE_W*slice +: SLICE_W] : bReg[SLICE_W*slice +: SLICE_W];
`else
  assign bSlice = bReg[SLICE_W*slice +: SLICE_W];
`endif

  add_16_bit uAdder (
    .a        (aSlice),
    .b        (bSlice),
    .carryIn  (carry),
    .sum      (sliceSum),
    .carryOut (sliceCout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slice    <= '0;
      carry    <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      subReg   <= 1'b0;
`endif
    end else if (accept) begin
      aReg  <= in_a;
      bReg  <= in_b;
      slice <= '0;
`ifdef ADD_SEQ_SUB_EN
      subReg <= in_sub;
      carry  <= in_sub ? 1'b1 : in_cin;
`else
      carry  <= in_cin;
`endif
    end else if (state == RUN) begin
      out_sum[SLICE_W*slice +: SLICE_W] <= sliceSum;
      carry <= sliceCout;
      if (lastSlice) begin
        out_cout <= sliceCout;
        slice    <= '0;
      end else begin
        slice <= slice + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
module tb_add_seq_ctrl;

  localparam int WIDTH  = 64;
  localparam int NSLICE = WIDTH / 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADD_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  // Reference: the true (WIDTH+1)-bit sum; subtraction is a + ~b + 1.
  function automatic logic [WIDTH:0] model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                           logic cin, logic sub);
    logic [WIDTH-1:0] bb;
    logic             c;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic check(string tag, logic [WIDTH:0] obs, logic [WIDTH:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acceptOp(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic cin, logic sub);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    check("in_ready before accept", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the falling edge right after the accept edge.
  task automatic waitCheck(string tag, logic [WIDTH:0] exp, int stall, bit scramble);
    int lat = 0;
    out_ready = (stall == 0);
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        in_a   = {$urandom, $urandom};
        in_b   = {$urandom, $urandom};
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, (WIDTH+1)'(lat), (WIDTH+1)'(NSLICE));
    check({tag, " result"}, {out_cout, out_sum}, exp);
    check({tag, " in_ready busy"}, in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " stall valid"}, out_valid, 1);
      check({tag, " stall result"}, {out_cout, out_sum}, exp);
      check({tag, " stall in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " valid drop"}, out_valid, 0);
    check({tag, " back idle"}, in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;
    int               st;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset result", {out_cout, out_sum}, 0);

    // 1: carry across slice 0 -> 1
    acceptOp(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    waitCheck("t1", 65'h0_0000_0000_0001_0000, 0, 1'b1);

    // 2: carry ripples through every slice
    acceptOp(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    waitCheck("t2", {1'b1, 64'h0}, 0, 1'b1);

    // 3: consumer stalls 5 cycles
    acceptOp(64'h1234_F0F0_0005_0001, 64'h0001_0F10_0001_0001, 1'b0, 1'b0);
    waitCheck("t3", {1'b0, 64'h1236_0000_0006_0002}, 5, 1'b1);

    // 4: reset while slice 2 is being added
    acceptOp(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4 abort in_ready", in_ready, 1);
    check("t4 abort out_valid", out_valid, 0);
    check("t4 abort result", {out_cout, out_sum}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4 no pulse", out_valid, 0);
    end
    acceptOp(64'd3, 64'd4, 1'b0, 1'b0);
    waitCheck("t4 post", 65'd7, 0, 1'b1);

    // 5: in_valid held with two queued ops
    in_a = 64'd1; in_b = 64'd1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_a = 64'd5; in_b = 64'd1; in_cin = 1'b1;
    waitCheck("t5 first", 65'd2, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waitCheck("t5 second", 65'd7, 0, 1'b1);

    // reset while holding a result in DONE
    acceptOp(64'd10, 64'd20, 1'b0, 1'b0);
    out_ready = 1'b0;
    repeat (NSLICE + 1) @(negedge clk);
    check("done hold valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("done abort valid", out_valid, 0);
    check("done abort in_ready", in_ready, 1);
    out_ready = 1'b1;

`ifdef ADD_SEQ_SUB_EN
    // 6: subtraction
    acceptOp(64'd5, 64'd7, 1'b0, 1'b1);
    waitCheck("t6 borrow", {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 0, 1'b1);
    acceptOp(64'd7, 64'd5, 1'b1, 1'b1);
    waitCheck("t6 no borrow", {1'b1, 64'd2}, 0, 1'b1);
`endif

    // randomized operands against the reference
    for (int n = 0; n < 16; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 4 == 0) rb = ~ra;
      rc = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      st = $urandom_range(0, 3);
      acceptOp(ra, rb, rc, rs);
      waitCheck("rand", model(ra, rb, rc, rs), st, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
